// File: rtl/image_mem_arbiter_if.sv
// Bus between the two image-BRAM readers, the arbiter and the BRAM read port.
// Handshake: a request is accepted at a rising clk_p edge where reqK and gntK are
// both high; addrK must be stable while reqK is high. The returned word appears on
// rvalidK/rdataK exactly two cycles after the accept, with no backpressure.
interface image_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 12
);
  logic                  req0;
  logic                  req1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;

  modport slave (
    input  req0, req1, addr0, addr1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_en, mem_addr, busy
  );

  modport master (
    output req0, req1, addr0, addr1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_en, mem_addr, busy
  );
endinterface

// File: rtl/image_mem_arbiter.sv
// Two-requester read arbiter for the image BRAM: burst-limited round-robin,
// one read per cycle, fixed two-cycle return latency routed by a tag pipeline.
module image_mem_arbiter #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 12,
  parameter int MAX_BURST  = 8   // legal range 1..15
) (
  input  logic                  clk_p,
  input  logic                  rst,
  image_mem_arbiter_if.slave    bus,
  output logic [1:0]            state_o,
  output logic [3:0]            burst_cnt_o,
  output logic                  last_served_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  state_e                state_q, state_d;
  logic [3:0]            burst_q, burst_d;
  logic                  last_q, last_d;
  logic                  gnt0, gnt1;
  logic [3:0]            burst_inc;

  logic                  mem_en_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  id1_q;
  logic                  v2_q;
  logic                  id2_q;
  logic                  rvalid0_q, rvalid1_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  // Saturating increment keeps a sole requester from wrapping the counter.
  assign burst_inc = (burst_q == BURST_MAX) ? burst_q : burst_q + 4'd1;

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      burst_q <= 4'd0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    last_d  = last_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (bus.req0 && bus.req1) begin
            gnt0 = last_q;
            gnt1 = !last_q;
          end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
          end
        end
        OWN0: begin
          if (bus.req0 && (!bus.req1 || (burst_q < BURST_MAX))) gnt0 = 1'b1;
          else if (bus.req1)                                     gnt1 = 1'b1;
        end
        OWN1: begin
          if (bus.req1 && (!bus.req0 || (burst_q < BURST_MAX))) gnt1 = 1'b1;
          else if (bus.req0)                                     gnt0 = 1'b1;
        end
        default: ;
      endcase

      if (gnt0) begin
        state_d = OWN0;
        last_d  = 1'b0;
        burst_d = (state_q == OWN0) ? burst_inc : 4'd1;
      end else if (gnt1) begin
        state_d = OWN1;
        last_d  = 1'b1;
        burst_d = (state_q == OWN1) ? burst_inc : 4'd1;
      end else begin
        state_d = IDLE;
        burst_d = 4'd0;
      end
    end
  end

  // Stage 1 of the tag pipeline is (mem_en_q, id1_q); stage 2 is (v2_q, id2_q),
  // aligned with mem_rdata from the BRAM.
  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      id1_q      <= 1'b0;
      v2_q       <= 1'b0;
      id2_q      <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      mem_en_q <= gnt0 | gnt1;
      if (gnt0 | gnt1) begin
        mem_addr_q <= gnt0 ? bus.addr0 : bus.addr1;
        id1_q      <= gnt1;
      end
      v2_q      <= mem_en_q;
      id2_q     <= id1_q;
      rvalid0_q <= v2_q && !id2_q;
      rvalid1_q <= v2_q && id2_q;
      if (v2_q && !id2_q) rdata0_q <= bus.mem_rdata;
      if (v2_q && id2_q)  rdata1_q <= bus.mem_rdata;
    end
  end

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.mem_en   = mem_en_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.busy     = bus.req0 | bus.req1 | mem_en_q | v2_q;

  assign state_o       = state_q;
  assign burst_cnt_o   = burst_q;
  assign last_served_o = last_q;

endmodule
